serial_subtractor_16: RTL and testbench

- Bit-serial, multi-cycle 16-bit subtractor with borrow-in. It is the inverse-direction counterpart of the combinational 16-bit full adder in the datapath.
- Computes sub_in1 - sub_in2 - bin, one bit per clock, LSB first, using a single 1-bit full-subtractor cell and a borrow flop.
- Used by the CPU's multi-cycle execute path. Start/busy/done handshake; results and flags are held until the next operation completes.

---
 rtl/serial_subtractor_16.sv | 117 +++++++++++
 tb/tb_serial_subtractor_16.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_16.sv
// Bit-serial subtractor: computes sub_in1 - sub_in2 - bin one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flop, with a start/busy/done handshake.

module serial_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module serial_subtractor_16 #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] sub_in1,
    input  logic [WIDTH-1:0] sub_in2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CNT_W-1:0] cnt;
    logic             brw;
    logic             s1;
    logic             s2;

    logic             d_bit;
    logic             brw_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    serial_sub_cell u_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .bi (brw),
        .d  (d_bit),
        .bo (brw_next)
    );

    // The new bit enters at the MSB so after WIDTH shifts the result is in place.
    assign res_next = {d_bit, res_sr[WIDTH-1:1]};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            s1     <= 1'b0;
            s2     <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= sub_in1;
                        b_sr  <= sub_in2;
                        s1    <= sub_in1[WIDTH-1];
                        s2    <= sub_in2[WIDTH-1];
                        brw   <= bin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_sr <= res_next;
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    brw    <= brw_next;
                    cnt    <= cnt + 1'b1;
                    // Visible results only change here; they hold through the next op's SHIFT.
                    if (last_bit) begin
                        diff  <= res_next;
                        bout  <= brw_next;
                        zero  <= (res_next == '0);
                        ovf   <= (s1 != s2) && (res_next[WIDTH-1] != s1);
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor_16.sv
// Randomized and directed bench for serial_subtractor_16 against an arithmetic reference model.

module tb_serial_subtractor_16;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] sub_in1;
    logic [15:0] sub_in2;
    logic        bin;
    logic        busy;
    logic        done;
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] exp_diff;
    logic        exp_bout;
    logic        exp_zero;
    logic        exp_ovf;

    serial_subtractor_16 #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sub_in1 (sub_in1),
        .sub_in2 (sub_in2),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout),
        .zero    (zero),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for borrow, signed range for overflow.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        int ua, ub, sa, sb, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sr = sa - sb - int'(bi);
        exp_diff = 16'((ua - ub - int'(bi)) & 32'hFFFF);
        exp_bout = (ua < ub + int'(bi));
        exp_zero = (exp_diff == 16'h0);
        exp_ovf  = (sr > 32767) || (sr < -32768);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        chk({tag, "_bout"}, 32'(bout), 32'(exp_bout));
        chk({tag, "_zero"}, 32'(zero), 32'(exp_zero));
        chk({tag, "_ovf"},  32'(ovf),  32'(exp_ovf));
    endtask

    // One operation; optional spurious start pulses at SHIFT cycles 3 and 10.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic bi, input bit noise);
        int lat, busy_cyc;
        logic [15:0] pd;
        logic pb, pz, po;
        pd = exp_diff; pb = exp_bout; pz = exp_zero; po = exp_ovf;
        @(negedge clk);
        sub_in1 = a; sub_in2 = b; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sub_in1 = 16'($urandom); sub_in2 = 16'($urandom); bin = 1'($urandom);
        lat = 0;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            if (lat == 8) begin
                chk({tag, "_hold_diff"}, 32'(diff), 32'(pd));
                chk({tag, "_hold_flags"}, {29'd0, bout, zero, ovf}, {29'd0, pb, pz, po});
            end
            start = noise && (lat == 3 || lat == 10);
            if (start) begin
                sub_in1 = 16'($urandom); sub_in2 = 16'($urandom); bin = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        if (busy) busy_cyc++;
        chk({tag, "_latency"}, 32'(lat), 32'd16);
        chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd17);
        model(a, b, bi);
        check_outputs(tag);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; sub_in1 = '0; sub_in2 = '0; bin = 1'b0;
        exp_diff = '0; exp_bout = 0; exp_zero = 0; exp_ovf = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
        check_outputs("reset");
        @(negedge clk); rst = 1'b0;

        do_op("d5m3",    16'd5,     16'd3,     1'b0, 1'b0);
        do_op("d0m1",    16'd0,     16'd1,     1'b0, 1'b0);
        do_op("d0m0b1",  16'd0,     16'd0,     1'b1, 1'b0);
        do_op("d8000m1", 16'h8000,  16'h0001,  1'b0, 1'b0);
        do_op("d7fffmf", 16'h7FFF,  16'hFFFF,  1'b0, 1'b0);
        do_op("deq",     16'h1234,  16'h1234,  1'b0, 1'b0);
        do_op("dhold",   16'hA5A5,  16'h0F0F,  1'b1, 1'b0);
        do_op("dnoise",  16'h4321,  16'h1111,  1'b0, 1'b1);
        do_op("d8000b1", 16'h8000,  16'h0000,  1'b1, 1'b0);

        for (int i = 0; i < 20; i++)
            do_op($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), 1'($urandom), i[0]);

        // Start held high: one operation every 18 cycles.
        @(negedge clk);
        sub_in1 = 16'd1000; sub_in2 = 16'd1; bin = 1'b0; start = 1'b1;
        dones = 0;
        for (int i = 0; i < 54; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        start = 1'b0;
        chk("b2b_dones", 32'(dones), 32'd3);
        model(16'd1000, 16'd1, 1'b0);
        check_outputs("b2b");
        repeat (20) @(posedge clk);

        // Reset in the middle of SHIFT aborts with no done pulse.
        @(negedge clk);
        sub_in1 = 16'hFFFF; sub_in2 = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        exp_diff = '0; exp_bout = 0; exp_zero = 0; exp_ovf = 0;
        chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
        check_outputs("midrst");
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);

        do_op("d100m58", 16'd100, 16'd58, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
